// File: rtl/cmd_mem_scheduler_pkg.sv
// Shared definitions for the command record memory path: record layout,
// field widths and the scheduler state encoding. The writer packs records
// with the same struct so both sides agree on the bit layout.
package cmd_mem_scheduler_pkg;

    localparam int FREQ_W     = 48;
    localparam int RATE_W     = 32;
    localparam int TIME_W     = 64;
    localparam int NIMP_W     = 16;
    localparam int TYPE_W     = 2;
    localparam int TDUR_W     = 32;
    localparam int LATE_CNT_W = 16;

    // Record layout, MSB first; total width is CMD_REC_W
    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [FREQ_W-1:0] freq_step;
        logic [RATE_W-1:0] freq_rate;
        logic [TIME_W-1:0] time_start;
        logic [NIMP_W-1:0] n_impulse;
        logic [TYPE_W-1:0] cmd_type;
        logic [TDUR_W-1:0] ti;
        logic [TDUR_W-1:0] tp;
        logic [TDUR_W-1:0] tblank1;
        logic [TDUR_W-1:0] tblank2;
    } cmd_rec_t;

    localparam int CMD_REC_W = $bits(cmd_rec_t);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WAIT,
        ISSUE
    } sched_state_t;

    // A record is late when its start time lies strictly in the past
    function automatic logic is_late(input logic [TIME_W-1:0] time_start,
                                     input logic [TIME_W-1:0] time_now);
        return time_start < time_now;
    endfunction

    // A record may go out once system time has reached its start time
    function automatic logic is_due(input logic [TIME_W-1:0] time_start,
                                    input logic [TIME_W-1:0] time_now);
        return time_now >= time_start;
    endfunction

endpackage

// File: rtl/cmd_mem_scheduler_if.sv
// Command handshake from the scheduler to the pulse-train generator.
// The scheduler drives the record fields and cmd_valid; the generator
// answers with cmd_ready.
interface cmd_mem_scheduler_if;
    import cmd_mem_scheduler_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [FREQ_W-1:0]     cmd_freq;
    logic [FREQ_W-1:0]     cmd_freq_step;
    logic [RATE_W-1:0]     cmd_freq_rate;
    logic [TDUR_W-1:0]     cmd_ti;
    logic [TDUR_W-1:0]     cmd_tp;
    logic [TDUR_W-1:0]     cmd_tblank1;
    logic [TDUR_W-1:0]     cmd_tblank2;
    logic [TIME_W-1:0]     cmd_time_start;
    logic [NIMP_W-1:0]     cmd_n_impulse;
    logic [TYPE_W-1:0]     cmd_type;

    modport master (
        output cmd_valid,
        output cmd_freq,
        output cmd_freq_step,
        output cmd_freq_rate,
        output cmd_ti,
        output cmd_tp,
        output cmd_tblank1,
        output cmd_tblank2,
        output cmd_time_start,
        output cmd_n_impulse,
        output cmd_type,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_freq,
        input  cmd_freq_step,
        input  cmd_freq_rate,
        input  cmd_ti,
        input  cmd_tp,
        input  cmd_tblank1,
        input  cmd_tblank2,
        input  cmd_time_start,
        input  cmd_n_impulse,
        input  cmd_type,
        output cmd_ready
    );

endinterface

// File: rtl/cmd_mem_scheduler.sv
// Command memory scheduler: pulls pending records from the shared command
// memory in FIFO order, holds each one until system time reaches its start
// time, then hands it to the pulse-train generator. Records whose start time
// has already passed when they are examined are dropped and counted.
module cmd_mem_scheduler
    import cmd_mem_scheduler_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2,
    parameter int REC_W  = 338
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [TIME_W-1:0]     TIME_NOW,
    input  logic [ADDR_W-1:0]     wr_ptr,
    output logic [ADDR_W-1:0]     rd_ptr,
    output logic [ADDR_W-1:0]     rdaddress,
    output logic                  rden,
    input  logic [REC_W-1:0]      rd_q,
    input  logic                  flush,
    cmd_mem_scheduler_if.master   cmd,
    output logic                  late_err,
    output logic [LATE_CNT_W-1:0] late_cnt,
    output logic                  busy
);

    // Last READ cycle: rd_q holds valid data RD_LAT cycles after rden
    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [1:0]    rd_cnt;
    cmd_rec_t      rec_q;

    logic          pending;
    logic          rd_done;
    logic          rec_late;
    logic          rec_due;
    logic          accept;
    logic          drop;

    logic          rden_c;
    logic          valid_c;
    logic          late_err_c;
    logic          busy_c;

    // Saturating increment so the late counter sticks at its maximum
    function automatic logic [LATE_CNT_W-1:0] sat_inc(input logic [LATE_CNT_W-1:0] v);
        return (v == {LATE_CNT_W{1'b1}}) ? v : v + LATE_CNT_W'(1);
    endfunction

    assign pending  = (rd_ptr != wr_ptr);
    assign rd_done  = (rd_cnt == RD_LAST);
    assign rec_late = is_late(rec_q.time_start, TIME_NOW);
    assign rec_due  = is_due(rec_q.time_start, TIME_NOW);
    assign accept   = (state == ISSUE) && cmd.cmd_ready && !flush;
    assign drop     = (state == CHECK) && rec_late && !flush;

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; flush returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (pending)       state_nxt = READ;
                READ:    if (rd_done)       state_nxt = CHECK;
                CHECK:   state_nxt = rec_late ? IDLE : WAIT;
                WAIT:    if (rec_due)       state_nxt = ISSUE;
                ISSUE:   if (cmd.cmd_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Moore/Mealy outputs of the FSM
    always_comb begin
        rden_c     = 1'b0;
        valid_c    = 1'b0;
        late_err_c = 1'b0;
        busy_c     = (state != IDLE);
        unique case (state)
            IDLE:    rden_c     = pending && !flush;
            CHECK:   late_err_c = rec_late && !flush;
            ISSUE:   valid_c    = 1'b1;
            default: ;
        endcase
    end

    // Read latency counter, running only while waiting for rd_q
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= 2'd0;
        end else if (state == READ && !rd_done) begin
            rd_cnt <= rd_cnt + 2'd1;
        end else begin
            rd_cnt <= 2'd0;
        end
    end

    // Record register: capture memory data on the last READ cycle
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= '0;
        end else if (state == READ && rd_done) begin
            rec_q <= rd_q;
        end
    end

    // Read pointer: resync on flush, advance on issue or drop
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (accept || drop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    // Late-drop counter; flush leaves it untouched
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            late_cnt <= '0;
        end else if (drop) begin
            late_cnt <= sat_inc(late_cnt);
        end
    end

    assign rdaddress = rd_ptr;
    assign rden      = rden_c;
    assign late_err  = late_err_c;
    assign busy      = busy_c;

    assign cmd.cmd_valid      = valid_c;
    assign cmd.cmd_freq       = rec_q.freq;
    assign cmd.cmd_freq_step  = rec_q.freq_step;
    assign cmd.cmd_freq_rate  = rec_q.freq_rate;
    assign cmd.cmd_time_start = rec_q.time_start;
    assign cmd.cmd_n_impulse  = rec_q.n_impulse;
    assign cmd.cmd_type       = rec_q.cmd_type;
    assign cmd.cmd_ti         = rec_q.ti;
    assign cmd.cmd_tp         = rec_q.tp;
    assign cmd.cmd_tblank1    = rec_q.tblank1;
    assign cmd.cmd_tblank2    = rec_q.tblank2;

endmodule

// File: tb/tb_cmd_mem_scheduler.sv
// Bench for cmd_mem_scheduler: memory model with two-cycle read latency,
// table of single-record vectors plus hand-written multi-cycle sequences,
// and a scoreboard of records expected on the command handshake.
module tb_cmd_mem_scheduler;
    import cmd_mem_scheduler_pkg::*;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int REC_W  = 338;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b0;
    logic [63:0]       time_now = 64'd0;
    logic [ADDR_W-1:0] wr_ptr = '0;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rdaddress;
    logic              rden;
    logic [REC_W-1:0]  rd_q;
    logic [REC_W-1:0]  rd_p1;
    logic              flush = 1'b0;
    logic              late_err;
    logic [15:0]       late_cnt;
    logic              busy;

    cmd_mem_scheduler_if bus();

    cmd_mem_scheduler #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .REC_W(REC_W)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .TIME_NOW  (time_now),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .rdaddress (rdaddress),
        .rden      (rden),
        .rd_q      (rd_q),
        .flush     (flush),
        .cmd       (bus),
        .late_err  (late_err),
        .late_cnt  (late_cnt),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Command memory, read latency 2
    logic [REC_W-1:0] mem [256];
    always @(posedge CLK) begin
        if (rden) rd_p1 <= mem[rdaddress];
        rd_q <= rd_p1;
    end

    int unsigned cyc_n = 0;
    always @(posedge CLK) cyc_n <= cyc_n + 1;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    cmd_rec_t    sb[$];
    logic [63:0] hs_tnow[$];
    int unsigned hs_cyc[$];
    bit          tick_en = 1'b0;
    logic [63:0] tick_max = 64'hFFFF_FFFF_FFFF_FFFF;
    bit          rise_seen;
    logic [63:0] rise_tnow;
    int          late_pulses = 0;
    bit          rden_seen;
    logic [7:0]  rden_addr;
    bit          prev_stall = 1'b0;
    bit          prev_valid = 1'b0;
    cmd_rec_t    prev_rec;
    int          exp_late = 0;
    logic [7:0]  exp_rd = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic cmd_rec_t bus_rec();
        cmd_rec_t r;
        r.freq       = bus.cmd_freq;
        r.freq_step  = bus.cmd_freq_step;
        r.freq_rate  = bus.cmd_freq_rate;
        r.time_start = bus.cmd_time_start;
        r.n_impulse  = bus.cmd_n_impulse;
        r.cmd_type   = bus.cmd_type;
        r.ti         = bus.cmd_ti;
        r.tp         = bus.cmd_tp;
        r.tblank1    = bus.cmd_tblank1;
        r.tblank2    = bus.cmd_tblank2;
        return r;
    endfunction

    function automatic cmd_rec_t mk_rec(input logic [63:0] ts);
        cmd_rec_t r;
        r.freq       = 48'({$urandom(), $urandom()});
        r.freq_step  = 48'({$urandom(), $urandom()});
        r.freq_rate  = $urandom();
        r.time_start = ts;
        r.n_impulse  = 16'($urandom());
        r.cmd_type   = 2'($urandom());
        r.ti         = $urandom();
        r.tp         = $urandom();
        r.tblank1    = $urandom();
        r.tblank2    = $urandom();
        return r;
    endfunction

    // Monitor on the falling edge, away from the active edge
    always @(negedge CLK) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(bus.cmd_valid), 64'd1);
                vec_cnt++;
                if (bus_rec() !== prev_rec) begin
                    err_cnt++;
                    $display("FAIL stall_fields: got %h, required %h", bus_rec(), prev_rec);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready && !flush) begin
                hs_tnow.push_back(time_now);
                hs_cyc.push_back(cyc_n);
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_issue: got time_start %0h, required no command",
                             bus.cmd_time_start);
                end else begin
                    cmd_rec_t e;
                    e = sb.pop_front();
                    if (bus_rec() !== e) begin
                        err_cnt++;
                        $display("FAIL issue_rec: got %h, required %h", bus_rec(), e);
                    end
                end
            end
            if (bus.cmd_valid && !prev_valid) begin
                rise_seen = 1'b1;
                rise_tnow = time_now;
            end
            if (late_err) late_pulses++;
            if (rden) begin
                check("rden_only_idle", 64'(busy), 64'd0);
                rden_seen = 1'b1;
                rden_addr = rdaddress;
            end
            prev_stall = bus.cmd_valid && !bus.cmd_ready && !flush;
            prev_rec   = bus_rec();
            prev_valid = bus.cmd_valid;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
        if (tick_en && time_now < tick_max) time_now = time_now + 64'd1;
    endtask

    task automatic put_rec(input cmd_rec_t r, input bit expect_issue);
        mem[wr_ptr] = r;
        if (expect_issue) sb.push_back(r);
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        bit ok;
        do begin
            cyc();
            n++;
            ok = !busy && !rden;
        end while (!ok && n < lim);
        check("idle_reached", 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!bus.cmd_valid && n < lim) begin
            cyc();
            n++;
        end
        check("valid_reached", 64'(bus.cmd_valid), 64'd1);
    endtask

    typedef struct {
        logic [63:0] ts;
        logic [63:0] t0;
        bit          run;
        bit          late;
        logic [63:0] exp_rise;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{ts: 64'd1000, t0: 64'd900, run: 1'b1, late: 1'b0, exp_rise: 64'd1001};
        tbl[1] = '{ts: 64'd500,  t0: 64'd600, run: 1'b1, late: 1'b1, exp_rise: 64'd0};
        tbl[2] = '{ts: 64'd700,  t0: 64'd700, run: 1'b0, late: 1'b0, exp_rise: 64'd700};
        tbl[3] = '{ts: 64'd699,  t0: 64'd700, run: 1'b0, late: 1'b1, exp_rise: 64'd0};
        tbl[4] = '{ts: 64'hFFFF_FFFF_FFFF_FFF0, t0: 64'hFFFF_FFFF_FFFF_FFD0, run: 1'b1,
                   late: 1'b0, exp_rise: 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[5] = '{ts: 64'd5, t0: 64'h8000_0000_0000_0000, run: 1'b0, late: 1'b1,
                   exp_rise: 64'd0};

        bus.cmd_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rd_ptr",    64'(rd_ptr), 64'd0);
        check("rst_rdaddress", 64'(rdaddress), 64'd0);
        check("rst_rden",      64'(rden), 64'd0);
        check("rst_valid",     64'(bus.cmd_valid), 64'd0);
        check("rst_late_err",  64'(late_err), 64'd0);
        check("rst_late_cnt",  64'(late_cnt), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_ts",        bus.cmd_time_start, 64'd0);
        check("rst_freq",      64'(bus.cmd_freq), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Single-record vectors
        for (int i = 0; i < 6; i++) begin
            time_now  = tbl[i].t0;
            tick_en   = tbl[i].run;
            rise_seen = 1'b0;
            put_rec(mk_rec(tbl[i].ts), !tbl[i].late);
            wait_idle(400);
            exp_late = exp_late + int'(tbl[i].late);
            exp_rd   = exp_rd + 8'd1;
            check($sformatf("v%0d_rd_ptr", i), 64'(rd_ptr), 64'(exp_rd));
            check($sformatf("v%0d_late_cnt", i), 64'(late_cnt), 64'(exp_late));
            check($sformatf("v%0d_late_pulses", i), 64'(late_pulses), 64'(exp_late));
            check($sformatf("v%0d_issued", i), 64'(rise_seen), 64'(!tbl[i].late));
            if (!tbl[i].late)
                check($sformatf("v%0d_rise_time", i), rise_tnow, tbl[i].exp_rise);
            check($sformatf("v%0d_sb_empty", i), 64'(sb.size()), 64'd0);
        end

        // Three records back to back; time held at 100, then released
        hs_tnow.delete();
        hs_cyc.delete();
        time_now = 64'd50;
        tick_en  = 1'b1;
        tick_max = 64'd100;
        put_rec(mk_rec(64'd100), 1'b1);
        put_rec(mk_rec(64'd100), 1'b1);
        put_rec(mk_rec(64'd200), 1'b1);
        for (int n = 0; n < 300 && hs_cyc.size() < 2; n++) cyc();
        check("b2b_two_issued", 64'(hs_cyc.size()), 64'd2);
        tick_max = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_idle(400);
        exp_rd = exp_rd + 8'd3;
        check("b2b_count", 64'(hs_tnow.size()), 64'd3);
        if (hs_tnow.size() == 3) begin
            check("b2b_gap",  64'(hs_cyc[1] - hs_cyc[0]), 64'(RD_LAT + 4));
            check("b2b_t0",   hs_tnow[0], 64'd100);
            check("b2b_t1",   hs_tnow[1], 64'd100);
            check("b2b_t2",   hs_tnow[2], 64'd201);
        end
        check("b2b_rd_ptr", 64'(rd_ptr), 64'(exp_rd));

        // Pointer wrap 255 -> 0, reached by flushing to wr_ptr=255
        wr_ptr = 8'd255;
        flush  = 1'b1;
        cyc();
        flush  = 1'b0;
        check("wrap_flush_rd_ptr", 64'(rd_ptr), 64'd255);
        check("wrap_flush_idle",   64'(busy), 64'd0);
        rden_seen = 1'b0;
        put_rec(mk_rec(time_now + 64'd10), 1'b1);
        wait_idle(200);
        check("wrap_rden_seen", 64'(rden_seen), 64'd1);
        check("wrap_rdaddress", 64'(rden_addr), 64'd255);
        check("wrap_rd_ptr",    64'(rd_ptr), 64'd0);

        // Ready stall in ISSUE: fields held, accepted on first ready
        bus.cmd_ready = 1'b0;
        put_rec(mk_rec(time_now + 64'd8), 1'b1);
        wait_valid(100);
        for (int n = 0; n < 20; n++) begin
            check("stall_hold", 64'(bus.cmd_valid), 64'd1);
            cyc();
        end
        check("stall_not_taken", 64'(sb.size()), 64'd1);
        bus.cmd_ready = 1'b1;
        cyc();
        check("stall_valid_drop", 64'(bus.cmd_valid), 64'd0);
        check("stall_rd_ptr",     64'(rd_ptr), 64'd1);
        check("stall_sb_empty",   64'(sb.size()), 64'd0);
        wait_idle(50);

        // Flush while waiting for a far-future start time
        put_rec(mk_rec(time_now + 64'd1000), 1'b0);
        repeat (8) cyc();
        check("flw_busy", 64'(busy), 64'd1);
        wr_ptr = 8'd5;
        flush  = 1'b1;
        cyc();
        flush  = 1'b0;
        check("flw_rd_ptr",  64'(rd_ptr), 64'd5);
        check("flw_idle",    64'(busy), 64'd0);
        check("flw_valid",   64'(bus.cmd_valid), 64'd0);
        check("flw_late",    64'(late_cnt), 64'(exp_late));
        repeat (10) cyc();
        check("flw_stays_idle", 64'(busy), 64'd0);

        // Flush and handshake together: flush wins
        bus.cmd_ready = 1'b0;
        put_rec(mk_rec(time_now + 64'd6), 1'b0);
        wait_valid(100);
        bus.cmd_ready = 1'b1;
        flush  = 1'b1;
        wr_ptr = 8'd9;
        cyc();
        flush  = 1'b0;
        check("flhs_rd_ptr", 64'(rd_ptr), 64'd9);
        check("flhs_valid",  64'(bus.cmd_valid), 64'd0);
        check("flhs_idle",   64'(busy), 64'd0);
        check("flhs_late",   64'(late_cnt), 64'(exp_late));

        // Reset while presenting a command
        bus.cmd_ready = 1'b0;
        put_rec(mk_rec(time_now + 64'd6), 1'b0);
        wait_valid(100);
        rst_n = 1'b0;
        #1;
        check("rstiss_valid",    64'(bus.cmd_valid), 64'd0);
        check("rstiss_rd_ptr",   64'(rd_ptr), 64'd0);
        check("rstiss_busy",     64'(busy), 64'd0);
        check("rstiss_late_cnt", 64'(late_cnt), 64'd0);
        wr_ptr = 8'd0;
        cyc();
        cyc();
        rst_n = 1'b1;
        bus.cmd_ready = 1'b1;
        repeat (10) cyc();
        check("rstiss_idle",  64'(busy), 64'd0);
        check("final_sb",     64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
